// File: rtl/alu_pkg.sv
// Package for the execute-stage ALU.
// Holds the datapath width, the opcode enumeration, the FSM state type and
// the select code used by the bitwise gate array.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  // 4-bit opcodes; codes 11..15 are undefined and produce result=0, zero=1.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BW_AND = 2'd0,
    BW_OR  = 2'd1,
    BW_XOR = 2'd2,
    BW_NOR = 2'd3
  } bw_sel_e;

endpackage

// File: rtl/bitwise_logic.sv
// Per-bit gate array for the bitwise ALU ops.
// Ports:
//   a, b  in  WIDTH  operands
//   sel   in  2      output select (bw_sel_e)
//   y     out WIDTH  selected AND/OR/XOR/NOR result
module bitwise_logic
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  bw_sel_e          sel,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] xor_v;
  logic [WIDTH-1:0] nor_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_v[i] = a[i] & b[i];
    assign or_v[i]  = a[i] | b[i];
    assign xor_v[i] = a[i] ^ b[i];
    assign nor_v[i] = ~(a[i] | b[i]);
  end

  always_comb begin
    y = and_v;
    case (sel)
      BW_AND:  y = and_v;
      BW_OR:   y = or_v;
      BW_XOR:  y = xor_v;
      BW_NOR:  y = nor_v;
      default: y = and_v;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage of the MIPS datapath.
// Single-cycle arithmetic/logic/compare ops; shifts iterate one bit per cycle.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and an offered result holds
// result/zero/overflow stable until out_ready is seen.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   op, a, b, shamt     opcode, rs, rt (shift source), shift amount
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   result, zero, overflow  registered result and flags
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow
);

  localparam int MSB = WIDTH - 1;

  state_e             state;
  alu_op_e            op_e;
  alu_op_e            shift_op;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   bw_y;
  bw_sel_e            bw_sel;
  logic [WIDTH-1:0]   calc;
  logic               calc_ovf;
  logic               is_shift;

  assign op_e      = alu_op_e'(op);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  assign sum  = a + b;
  assign diff = a - b;

  bitwise_logic #(.WIDTH(WIDTH)) u_bitwise (
    .a   (a),
    .b   (b),
    .sel (bw_sel),
    .y   (bw_y)
  );

  assign is_shift = (op_e == OP_SLL) || (op_e == OP_SRL) || (op_e == OP_SRA);

  // Single-cycle result. Shift opcodes yield b here, which is the correct
  // answer for the shamt==0 case; non-zero shifts go through the SHIFT state.
  always_comb begin
    calc     = '0;
    calc_ovf = 1'b0;
    bw_sel   = BW_AND;
    case (op_e)
      OP_ADD: begin
        calc     = sum;
        calc_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        calc     = diff;
        calc_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: begin bw_sel = BW_AND; calc = bw_y; end
      OP_OR:  begin bw_sel = BW_OR;  calc = bw_y; end
      OP_XOR: begin bw_sel = BW_XOR; calc = bw_y; end
      OP_NOR: begin bw_sel = BW_NOR; calc = bw_y; end
      OP_SLT:  calc = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: calc = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: calc = b;
      default: calc = '0;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    acc_next = acc;
    case (shift_op)
      OP_SLL:  acc_next = {acc[MSB-1:0], 1'b0};
      OP_SRL:  acc_next = {1'b0, acc[MSB:1]};
      default: acc_next = {acc[MSB], acc[MSB:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      shift_op <= OP_SLL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_shift && (shamt != '0)) begin
              acc      <= b;
              cnt      <= shamt;
              shift_op <= op_e;
              state    <= ST_SHIFT;
            end else begin
              result   <= calc;
              zero     <= (calc == '0);
              overflow <= calc_ovf;
              state    <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHAMT_W'(1);
          // Last step: commit the shifted value directly so DONE follows
          // exactly shamt cycles after SHIFT is entered.
          if (cnt == SHAMT_W'(1)) begin
            result   <= acc_next;
            zero     <= (acc_next == '0);
            overflow <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops
// checked against a behavioural reference model and an expected-value queue.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   shamt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int n_vec;
  int n_miss;

  logic [W-1:0] exp_q[$];
  logic         ovf_q[$];
  int           lat_q[$];

  alu_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_res(input logic [3:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic [4:0] s);
    logic signed [W-1:0] ys;
    ys = y;
    case (o)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return ~(x | y);
      4'd6:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd7:  return (x < y) ? 32'd1 : 32'd0;
      4'd8:  return y << s;
      4'd9:  return y >> s;
      4'd10: return ys >>> s;
      default: return '0;
    endcase
  endfunction

  // Overflow from exact integer arithmetic: out of signed 32-bit range.
  function automatic logic ref_ovf(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    longint s;
    if (o == 4'd0) s = longint'($signed(x)) + longint'($signed(y));
    else if (o == 4'd1) s = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic [4:0] s);
    if ((o >= 4'd8) && (o <= 4'd10) && (s != 0)) return int'(s) + 1;
    return 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_junk();
    op    = 4'($urandom_range(0, 15));
    a     = $urandom;
    b     = $urandom;
    shamt = 5'($urandom_range(0, 31));
  endtask

  // Offer one op; returns just after the accepting edge (unit assumed idle).
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [4:0] s);
    @(negedge clk);
    op = o; a = x; b = y; shamt = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drive_junk();
  endtask

  // Count negedges after the accepting edge until out_valid; -1 on timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) break;
      if (lat > 100) begin
        lat = -1;
        break;
      end
    end
  endtask

  // Called at a negedge with out_valid high; consumes the result.
  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    drive_junk();
    repeat (3) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++;
    if (result !== '0) begin n_miss++; $display("FAIL reset_result: got %h want 0", result); end
    n_vec++;
    if (zero !== 1'b0 || overflow !== 1'b0) begin
      n_miss++; $display("FAIL reset_flags: got z=%b o=%b want 0 0", zero, overflow);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_xor();
    int lat;
    issue(4'd4, 32'h1FF80000, 32'h00800000, 5'd0);
    wait_result(lat);
    n_vec++;
    if (result !== 32'h1F780000 || zero !== 1'b0 || lat != 1) begin
      n_miss++; $display("FAIL xor_basic: got %h z=%b lat=%0d want 1f780000 z=0 lat=1", result, zero, lat);
    end
    release_result();
    issue(4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    wait_result(lat);
    n_vec++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_miss++; $display("FAIL xor_zero: got %h z=%b want 0 z=1", result, zero);
    end
    release_result();
  endtask

  task automatic test_arith();
    int lat;
    issue(4'd0, 32'h7FFFFFFF, 32'h1, 5'd0);
    wait_result(lat);
    n_vec++;
    if (result !== 32'h80000000 || overflow !== 1'b1) begin
      n_miss++; $display("FAIL add_ovf: got %h o=%b want 80000000 o=1", result, overflow);
    end
    release_result();
    issue(4'd1, 32'h0, 32'h1, 5'd0);
    wait_result(lat);
    n_vec++;
    if (result !== 32'hFFFFFFFF || overflow !== 1'b0) begin
      n_miss++; $display("FAIL sub_neg: got %h o=%b want ffffffff o=0", result, overflow);
    end
    release_result();
    issue(4'd6, 32'h80000000, 32'h1, 5'd0);
    wait_result(lat);
    n_vec++;
    if (result !== 32'h1) begin n_miss++; $display("FAIL slt: got %h want 1", result); end
    release_result();
    issue(4'd7, 32'h80000000, 32'h1, 5'd0);
    wait_result(lat);
    n_vec++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_miss++; $display("FAIL sltu: got %h z=%b want 0 z=1", result, zero);
    end
    release_result();
    issue(4'd13, 32'h12345678, 32'h9ABCDEF0, 5'd7);
    wait_result(lat);
    n_vec++;
    if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0 || lat != 1) begin
      n_miss++; $display("FAIL undef_op: got %h z=%b o=%b lat=%0d want 0 1 0 lat=1", result, zero, overflow, lat);
    end
    release_result();
  endtask

  task automatic test_shift();
    int lat;
    issue(4'd10, 32'h80000000, 32'h80000000, 5'd31);
    b = 32'h0;  // the latched operand must be what gets shifted
    wait_result(lat);
    n_vec++;
    if (result !== 32'hFFFFFFFF || lat != 32) begin
      n_miss++; $display("FAIL sra_31: got %h lat=%0d want ffffffff lat=32", result, lat);
    end
    release_result();
    issue(4'd8, 32'h0, 32'hA5A5_0F0F, 5'd0);
    wait_result(lat);
    n_vec++;
    if (result !== 32'hA5A5_0F0F || lat != 1) begin
      n_miss++; $display("FAIL sll_0: got %h lat=%0d want a5a50f0f lat=1", result, lat);
    end
    release_result();
    issue(4'd9, 32'h0, 32'h8000_0001, 5'd4);
    wait_result(lat);
    n_vec++;
    if (result !== 32'h0800_0000 || lat != 5) begin
      n_miss++; $display("FAIL srl_4: got %h lat=%0d want 08000000 lat=5", result, lat);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(4'd0, 32'd5, 32'd7, 5'd0);
    wait_result(lat);
    // Offer a second op while the first result is still held.
    op = 4'd4; a = 32'h000000F0; b = 32'h0000000F; shamt = 5'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'd12 || in_ready !== 1'b0) begin
        n_miss++;
        $display("FAIL bp_hold[%0d]: got v=%b r=%h rdy=%b want v=1 r=0000000c rdy=0", i, out_valid, result, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_miss++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drive_junk();
    wait_result(lat);
    n_vec++;
    if (result !== 32'h000000FF || lat != 1) begin
      n_miss++; $display("FAIL bp_next_op: got %h lat=%0d want 000000ff lat=1", result, lat);
    end
    release_result();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    logic saw;
    issue(4'd9, 32'h0, 32'hFFFFFFFF, 5'd20);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw = 1'b1;
    end
    n_vec++;
    if (saw !== 1'b0) begin n_miss++; $display("FAIL mid_shift_reset: got out_valid rise=%b want 0", saw); end
    issue(4'd1, 32'd10, 32'd3, 5'd0);
    wait_result(lat);
    n_vec++;
    if (result !== 32'd7 || lat != 1) begin
      n_miss++; $display("FAIL after_reset_op: got %h lat=%0d want 00000007 lat=1", result, lat);
    end
    release_result();
  endtask

  task automatic test_random();
    int lat;
    logic [3:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [4:0]   s;
    logic [W-1:0] exp_r;
    logic         exp_o;
    int           exp_l;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = {1'b1, 31'($urandom)};
      s = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      exp_q.push_back(ref_res(o, x, y, s));
      ovf_q.push_back(ref_ovf(o, x, y));
      lat_q.push_back(ref_lat(o, s));
      issue(o, x, y, s);
      wait_result(lat);
      exp_r = exp_q.pop_front();
      exp_o = ovf_q.pop_front();
      exp_l = lat_q.pop_front();
      n_vec++;
      if (result !== exp_r || zero !== (exp_r == '0) || overflow !== exp_o || lat != exp_l) begin
        n_miss++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h sh=%0d: got %h z=%b o=%b lat=%0d want %h z=%b o=%b lat=%0d",
                 i, o, x, y, s, result, zero, overflow, lat, exp_r, (exp_r == '0), exp_o, exp_l);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_result();
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_vec = 0;
    n_miss = 0;
    test_reset();
    test_xor();
    test_arith();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
